// File: rtl/dmem_mmio.sv
// Data memory with a small memory-mapped I/O block: word RAM at 0x0000_xxxx,
// LEDS / CYCLES / CMP / STATUS registers at 0xFFFF_0000..0xFFFF_000C.
// Ports:
//   clk, reset   - single clock, synchronous active-high reset
//   memwrite     - store strobe, committed at the next rising edge
//   aluout       - byte address
//   writedata    - store data
//   readdata     - combinational load data for aluout
//   led          - LEDS register
//   irq          - registered timer match flag (STATUS[0])
module dmem_mmio #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] OFF_LEDS   = 2'd0;
    localparam logic [1:0] OFF_CYCLES = 2'd1;
    localparam logic [1:0] OFF_CMP    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          ram_sel;
    logic          mmio_sel;
    logic          aligned;
    logic          ram_we;
    logic          mmio_we;
    logic          misalign_set;
    logic          match_set;
    logic          status_we;

    logic [7:0]    leds_q;
    logic [31:0]   cycles_q;
    logic [31:0]   cmp_q;
    logic          match_q;
    logic          misalign_q;

    // Address decode
    assign ram_sel  = (aluout[31:16] == 16'h0000);
    assign mmio_sel = (aluout[31:16] == 16'hFFFF) && (aluout[15:4] == 12'h000);
    assign aligned  = (aluout[1:0] == 2'b00);
    assign idx      = aluout[AW+1:2];

    // Misaligned stores are dropped everywhere; they only raise MISALIGN.
    assign ram_we       = memwrite && aligned && ram_sel && !reset;
    assign mmio_we      = memwrite && aligned && mmio_sel;
    assign misalign_set = memwrite && !aligned;
    assign status_we    = mmio_we && (aluout[3:2] == OFF_STATUS);
    // Compare against pre-edge CMP, so a same-cycle CMP write does not affect it.
    assign match_set    = (cycles_q == cmp_q);

    // RAM array, no reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= writedata;
        end
    end

    // MMIO registers; reset overrides counting, flag sets and writes
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q     <= 8'h00;
            cycles_q   <= 32'h0000_0000;
            cmp_q      <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (mmio_we && (aluout[3:2] == OFF_LEDS)) begin
                leds_q <= writedata[7:0];
            end
            if (mmio_we && (aluout[3:2] == OFF_CMP)) begin
                cmp_q <= writedata;
            end
            // Write-1-to-clear, with a same-edge set taking priority
            match_q    <= match_set    || (match_q    && !(status_we && writedata[0]));
            misalign_q <= misalign_set || (misalign_q && !(status_we && writedata[1]));
        end
    end

    // Zero-latency load path
    always_comb begin
        readdata = 32'h0000_0000;
        if (ram_sel) begin
            readdata = mem[idx];
        end else if (mmio_sel) begin
            case (aluout[3:2])
                OFF_LEDS:   readdata = {24'h000000, leds_q};
                OFF_CYCLES: readdata = cycles_q;
                OFF_CMP:    readdata = cmp_q;
                OFF_STATUS: readdata = {30'h0, misalign_q, match_q};
                default:    readdata = 32'h0000_0000;
            endcase
        end
    end

    assign led = leds_q;
    assign irq = match_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed vector table, hand-written
// timer / reset sequences, then randomized traffic against a reference model.
module tb_dmem_mmio;

    localparam int unsigned DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic        irq;

    int passed = 0;
    int total  = 0;

    dmem_mmio #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .led       (led),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_leds;
    logic [31:0] m_cyc;
    logic [31:0] m_cmp;
    logic        m_match;
    logic        m_mis;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:16] == 16'h0000)
            return m_mem[(a / 4) % DEPTH];
        if (a[31:16] == 16'hFFFF && a[15:4] == 12'h000) begin
            case ((a % 16) / 4)
                0: return {24'h0, m_leds};
                1: return m_cyc;
                2: return m_cmp;
                default: return {30'h0, m_mis, m_match};
            endcase
        end
        return 32'h0;
    endfunction

    // What one rising edge does to the architectural state
    task automatic model_edge(input logic r, input logic mw,
                              input logic [31:0] a, input logic [31:0] wd);
        logic hit;
        logic bad;
        if (r) begin
            m_leds = 8'h00; m_cyc = 32'h0; m_cmp = 32'hFFFF_FFFF;
            m_match = 1'b0; m_mis = 1'b0;
            return;
        end
        hit = (m_cyc == m_cmp);
        bad = mw && (a % 4 != 0);
        if (mw && !bad) begin
            if (a[31:16] == 16'h0000) begin
                m_mem[(a / 4) % DEPTH] = wd;
            end else if (a[31:16] == 16'hFFFF && a[15:4] == 12'h000) begin
                case (a % 16)
                    0:  m_leds = wd[7:0];
                    8:  m_cmp = wd;
                    12: begin
                        if (wd[0]) m_match = 1'b0;
                        if (wd[1]) m_mis = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        if (hit) m_match = 1'b1;
        if (bad) m_mis = 1'b1;
        m_cyc = m_cyc + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Drive inputs just after the falling edge and let them settle
    task automatic set_in(input logic r, input logic mw,
                          input logic [31:0] a, input logic [31:0] wd);
        reset = r; memwrite = mw; aluout = a; writedata = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(reset, memwrite, aluout, writedata);
        @(negedge clk);
    endtask

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic [7:0]  led;
        logic        irq;
    } vec_t;

    vec_t vt [18];

    logic [31:0] ra;
    logic [31:0] rwd;
    logic        rmw;
    logic        rrst;

    initial begin
        // Row k is applied in the cycle where CYCLES == k
        vt[0]  = '{1'b0, 32'hFFFF_0004, 32'h0,          1'b1, 32'd0,          8'h00, 1'b0};
        vt[1]  = '{1'b0, 32'hFFFF_0008, 32'h0,          1'b1, 32'hFFFF_FFFF,  8'h00, 1'b0};
        vt[2]  = '{1'b0, 32'hFFFF_000C, 32'h0,          1'b1, 32'h0,          8'h00, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 32'h0,          8'h00, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0110, 32'h0,          1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
        vt[6]  = '{1'b1, 32'h0000_0012, 32'h1234_5678,  1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
        vt[7]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
        vt[8]  = '{1'b0, 32'hFFFF_000C, 32'h0,          1'b1, 32'h2,          8'h00, 1'b0};
        vt[9]  = '{1'b1, 32'hFFFF_000C, 32'h2,          1'b1, 32'h2,          8'h00, 1'b0};
        vt[10] = '{1'b0, 32'hFFFF_000C, 32'h0,          1'b1, 32'h0,          8'h00, 1'b0};
        vt[11] = '{1'b1, 32'hFFFF_0000, 32'hFFFF_FFA5,  1'b1, 32'h0,          8'h00, 1'b0};
        vt[12] = '{1'b0, 32'hFFFF_0000, 32'h0,          1'b1, 32'hA5,         8'hA5, 1'b0};
        vt[13] = '{1'b0, 32'h0001_0000, 32'h0,          1'b1, 32'h0,          8'hA5, 1'b0};
        vt[14] = '{1'b1, 32'hFFFF_0004, 32'h0,          1'b1, 32'd14,         8'hA5, 1'b0};
        vt[15] = '{1'b0, 32'hFFFF_0004, 32'h0,          1'b1, 32'd15,         8'hA5, 1'b0};
        vt[16] = '{1'b1, 32'h0001_0000, 32'h0000_1234,  1'b1, 32'h0,          8'hA5, 1'b0};
        vt[17] = '{1'b0, 32'hFFFF_000C, 32'h0,          1'b1, 32'h0,          8'hA5, 1'b0};

        // Power-up reset
        set_in(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_0008, 32'h0);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_cmp", readdata, 32'hFFFF_FFFF);

        // Give every RAM word a known value
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_in(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i) * 32'h0101_0101);
            tick();
        end

        // Restart the counter, then run the vector table
        set_in(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 18; k++) begin
            set_in(1'b0, vt[k].mw, vt[k].a, vt[k].wd);
            if (vt[k].chk_rd) chk($sformatf("vec%0d_rd", k), readdata, vt[k].rd);
            chk($sformatf("vec%0d_led", k), 32'(led), 32'(vt[k].led));
            chk($sformatf("vec%0d_irq", k), 32'(irq), 32'(vt[k].irq));
            tick();
        end

        // Timer: CMP=5, irq rises in the cycle CYCLES reads 6
        set_in(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_0008, 32'd5);
        tick();
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
            chk($sformatf("timer_cyc%0d", k), readdata, 32'(k));
            chk($sformatf("timer_irq%0d", k), 32'(irq), (k == 6) ? 32'h1 : 32'h0);
            tick();
        end
        set_in(1'b0, 1'b1, 32'hFFFF_000C, 32'h0);
        chk("timer_hold", 32'(irq), 32'h1);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
        chk("timer_w0_status", readdata, 32'h1);
        chk("timer_w0_irq", 32'(irq), 32'h1);
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_000C, 32'h1);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
        chk("timer_clr_status", readdata, 32'h0);
        chk("timer_clr_irq", 32'(irq), 32'h0);
        tick();

        // Clear in the very cycle CYCLES==CMP: set wins
        set_in(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_0008, 32'd3);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_000C, 32'h1);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
        chk("race_status", readdata, 32'h1);
        chk("race_irq", 32'(irq), 32'h1);
        tick();

        // CMP written in the equality cycle compares against the old CMP
        set_in(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_0008, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
        chk("precmp_status", readdata, 32'h0);
        tick();

        // Reset mid-operation with LEDS=A5 and MATCH=1
        set_in(1'b0, 1'b1, 32'hFFFF_0000, 32'hA5);
        tick();
        set_in(1'b0, 1'b1, 32'hFFFF_0008, 32'd4);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
        chk("pre_rst_led", 32'(led), 32'hA5);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        tick();
        set_in(1'b1, 1'b1, 32'hFFFF_0000, 32'h5A);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_cyc0", readdata, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
        chk("rst_cyc1", readdata, 32'h1);
        tick();
        set_in(1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
        tick();
        set_in(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        chk("rst_ram_kept", readdata, 32'hDEAD_BEEF);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rrst = ($urandom_range(0, 59) == 0);
            rmw  = ($urandom_range(0, 1) == 1);
            rwd  = $urandom;
            case ($urandom_range(0, 3))
                0, 1: begin
                    ra = {16'h0000, 16'($urandom)};
                    if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
                end
                2: begin
                    ra = {16'hFFFF, 12'h000, 2'($urandom_range(0, 3)), 2'b00};
                    if ($urandom_range(0, 9) == 0) ra[1:0] = 2'($urandom_range(1, 3));
                    if (ra[3:0] == 4'h8) rwd = m_cyc + 32'($urandom_range(0, 6));
                    if (ra[3:0] == 4'hC) rwd = 32'($urandom_range(0, 3));
                end
                default: ra = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
            endcase
            set_in(rrst, rmw, ra, rwd);
            chk("rand_rd", readdata, model_read(ra));
            chk("rand_led", 32'(led), 32'(m_leds));
            chk("rand_irq", 32'(irq), 32'(m_match));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
